// File: rtl/morse_pkg.sv
// morse_pkg: shared FSM states, ASCII constants and symbol limit for the Morse decoder
package morse_pkg;
  typedef enum logic [2:0] {S_IDLE, S_PRESS, S_GAP, S_EMIT, S_SPACE} state_e;
  localparam logic [7:0] ASCII_QMARK = 8'h3F;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [2:0] SYM_MAX = 3'd5;
endpackage

// File: rtl/morse_lut.sv
// morse_lut: maps {symbol count, symbols} (bit i = symbol i, 1 = dash) to ITU A-Z/0-9 ASCII
module morse_lut (
  input  logic [2:0] len,
  input  logic [4:0] bits,
  output logic [7:0] ascii,
  output logic       hit
);
  always_comb begin
    ascii = 8'h00;
    case ({len, bits})
      {3'd2, 5'b00010}: ascii = "A";
      {3'd4, 5'b00001}: ascii = "B";
      {3'd4, 5'b00101}: ascii = "C";
      {3'd3, 5'b00001}: ascii = "D";
      {3'd1, 5'b00000}: ascii = "E";
      {3'd4, 5'b00100}: ascii = "F";
      {3'd3, 5'b00011}: ascii = "G";
      {3'd4, 5'b00000}: ascii = "H";
      {3'd2, 5'b00000}: ascii = "I";
      {3'd4, 5'b01110}: ascii = "J";
      {3'd3, 5'b00101}: ascii = "K";
      {3'd4, 5'b00010}: ascii = "L";
      {3'd2, 5'b00011}: ascii = "M";
      {3'd2, 5'b00001}: ascii = "N";
      {3'd3, 5'b00111}: ascii = "O";
      {3'd4, 5'b00110}: ascii = "P";
      {3'd4, 5'b01011}: ascii = "Q";
      {3'd3, 5'b00010}: ascii = "R";
      {3'd3, 5'b00000}: ascii = "S";
      {3'd1, 5'b00001}: ascii = "T";
      {3'd3, 5'b00100}: ascii = "U";
      {3'd4, 5'b01000}: ascii = "V";
      {3'd3, 5'b00110}: ascii = "W";
      {3'd4, 5'b01001}: ascii = "X";
      {3'd4, 5'b01101}: ascii = "Y";
      {3'd4, 5'b00011}: ascii = "Z";
      {3'd5, 5'b11111}: ascii = "0";
      {3'd5, 5'b11110}: ascii = "1";
      {3'd5, 5'b11100}: ascii = "2";
      {3'd5, 5'b11000}: ascii = "3";
      {3'd5, 5'b10000}: ascii = "4";
      {3'd5, 5'b00000}: ascii = "5";
      {3'd5, 5'b00001}: ascii = "6";
      {3'd5, 5'b00011}: ascii = "7";
      {3'd5, 5'b00111}: ascii = "8";
      {3'd5, 5'b01111}: ascii = "9";
      default:          ascii = 8'h00;
    endcase
    hit = ascii != 8'h00;
  end
endmodule

// File: rtl/morse_decoder.sv
// morse_decoder: times button presses/releases in ms ticks and emits decoded ASCII characters
module morse_decoder
  import morse_pkg::*;
#(
  parameter int PRESCALE      = 27000,
  parameter int DOT_MAX_MS    = 200,
  parameter int LETTER_GAP_MS = 600,
  parameter int WORD_GAP_MS   = 1400
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn,
  output logic       char_valid,
  output logic [7:0] char_code,
  output logic       char_err
);
  localparam int PW = $clog2(PRESCALE + 1);
  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [10:0]   ms_q, ms_d;
  logic [2:0]    sym_len_q, sym_len_d;
  logic [4:0]    sym_bits_q, sym_bits_d;
  logic          ovf_q, ovf_d, armed_q, armed_d;
  logic          valid_q, valid_d, err_q, err_d;
  logic [7:0]    code_q, code_d;
  logic [7:0]    lut_ascii;
  logic          lut_hit, tick;
  morse_lut u_lut (
    .len   (sym_len_q),
    .bits  (sym_bits_q),
    .ascii (lut_ascii),
    .hit   (lut_hit)
  );
  always_comb begin
    tick       = pre_q == PW'(PRESCALE - 1);
    pre_d      = tick ? '0 : pre_q + 1'b1;
    ms_d       = (tick && ms_q != 11'h7FF) ? ms_q + 11'd1 : ms_q;
    state_d    = state_q;
    sym_len_d  = sym_len_q;
    sym_bits_d = sym_bits_q;
    ovf_d      = ovf_q;
    armed_d    = armed_q;
    valid_d    = 1'b0;
    code_d     = code_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: state_d = btn ? S_PRESS :
                        (armed_q && ms_d >= 11'(WORD_GAP_MS - LETTER_GAP_MS)) ? S_SPACE : S_IDLE;
      S_PRESS: if (!btn) begin
        // a zero-length press is a glitch and leaves the letter untouched
        state_d = (ms_q != 11'd0 || sym_len_q != 3'd0) ? S_GAP : S_IDLE;
        if (ms_q != 11'd0) begin
          if (sym_len_q == SYM_MAX) ovf_d = 1'b1;
          else begin
            sym_bits_d[sym_len_q] = ms_q >= 11'(DOT_MAX_MS);
            sym_len_d             = sym_len_q + 3'd1;
          end
        end
      end
      S_GAP: state_d = ms_d >= 11'(LETTER_GAP_MS) ? S_EMIT : btn ? S_PRESS : S_GAP;
      S_EMIT: begin
        valid_d    = 1'b1;
        code_d     = (lut_hit && !ovf_q) ? lut_ascii : ASCII_QMARK;
        err_d      = !(lut_hit && !ovf_q);
        sym_len_d  = 3'd0;
        sym_bits_d = 5'd0;
        ovf_d      = 1'b0;
        armed_d    = 1'b1;
        state_d    = S_IDLE;
      end
      S_SPACE: begin
        valid_d = 1'b1;
        code_d  = ASCII_SPACE;
        err_d   = 1'b0;
        armed_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) begin
      pre_d = '0;
      ms_d  = 11'd0;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      pre_q      <= '0;
      ms_q       <= 11'd0;
      sym_len_q  <= 3'd0;
      sym_bits_q <= 5'd0;
      ovf_q      <= 1'b0;
      armed_q    <= 1'b0;
      valid_q    <= 1'b0;
      code_q     <= 8'h00;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      pre_q      <= pre_d;
      ms_q       <= ms_d;
      sym_len_q  <= sym_len_d;
      sym_bits_q <= sym_bits_d;
      ovf_q      <= ovf_d;
      armed_q    <= armed_d;
      valid_q    <= valid_d;
      code_q     <= code_d;
      err_q      <= err_d;
    end
  end
  assign char_valid = valid_q;
  assign char_code  = code_q;
  assign char_err   = err_q;
endmodule

// File: tb/tb_morse_decoder.sv
// tb_morse_decoder: directed press/release sequences with hand-computed expected characters
module tb_morse_decoder;
  localparam int PS = 10;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn = 1'b0;
  logic       char_valid;
  logic [7:0] char_code;
  logic       char_err;
  int         nchk = 0;
  int         nerr = 0;
  int         cyc = 0;
  int         npulse = 0;
  int         last_cyc = 0;
  int         pulse_gap = 0;
  logic [7:0] last_code = 8'h00;
  logic       last_err = 1'b0;
  int         base;
  morse_decoder #(.PRESCALE(PS)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .char_valid (char_valid),
    .char_code  (char_code),
    .char_err   (char_err)
  );
  always #5 clk = ~clk;
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (char_valid) begin
      npulse    <= npulse + 1;
      pulse_gap <= cyc - last_cyc;
      last_cyc  <= cyc;
      last_code <= char_code;
      last_err  <= char_err;
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    btn   = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask
  // ms_cnt reads exactly n on the edge that samples the release
  task automatic press(input int n);
    btn = 1'b1;
    repeat (n * PS + 1) @(negedge clk);
    btn = 1'b0;
  endtask
  task automatic rel(input int n);
    btn = 1'b0;
    repeat (n * PS) @(negedge clk);
  endtask
  initial begin
    do_reset();
    @(negedge clk);
    chk("rst_valid", char_valid, 0);
    chk("rst_code", char_code, 8'h00);
    chk("rst_err", char_err, 0);
    base = npulse;
    press(100); rel(700);
    chk("e_cnt", npulse - base, 1);
    chk("e_code", last_code, 8'h45);
    chk("e_err", last_err, 0);
    rel(2300);
    chk("sp_cnt", npulse - base, 2);
    chk("sp_code", last_code, 8'h20);
    chk("sp_err", last_err, 0);
    chk("sp_gap", pulse_gap, 800 * PS + 1);
    do_reset();
    base = npulse;
    press(100); rel(100); press(300); rel(700);
    chk("a_cnt", npulse - base, 1);
    chk("a_code", last_code, 8'h41);
    chk("a_err", last_err, 0);
    do_reset();
    base = npulse;
    press(200); rel(20); press(20); rel(20); press(20); rel(20); press(20); rel(620);
    chk("b_cnt", npulse - base, 1);
    chk("b_code", last_code, 8'h42);
    do_reset();
    base = npulse;
    press(199); rel(700);
    chk("dot199_code", last_code, 8'h45);
    press(200); rel(700);
    chk("dash200_code", last_code, 8'h54);
    chk("edge_cnt", npulse - base, 2);
    do_reset();
    base = npulse;
    for (int i = 0; i < 5; i++) begin
      press(20); rel(20);
    end
    press(20); rel(700);
    chk("ovf_code", last_code, 8'h3F);
    chk("ovf_err", last_err, 1);
    press(20); rel(620);
    chk("post_ovf_code", last_code, 8'h45);
    chk("post_ovf_err", last_err, 0);
    chk("ovf_cnt", npulse - base, 2);
    press(20); rel(20); press(20); rel(20);
    btn = 1'b1;
    repeat (50 * PS) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    btn   = 1'b0;
    chk("mid_rst_code", char_code, 8'h00);
    chk("mid_rst_valid", char_valid, 0);
    chk("mid_rst_err", char_err, 0);
    base = npulse;
    press(20); rel(620);
    chk("mid_rst_cnt", npulse - base, 1);
    chk("mid_rst_e", last_code, 8'h45);
    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule

// File: doc/morse_decoder.md
MORSE_DECODER -- requirements
Module: morse_decoder

Interface
REQ-001 Parameter PRESCALE, default 27000, clk cycles per 1 ms time tick (27 MHz system clock).
REQ-002 Parameter DOT_MAX_MS, default 200, press durations below this in ticks are dots; durations at or above it are dashes.
REQ-003 Parameter LETTER_GAP_MS, default 600, release duration in ticks that ends a letter.
REQ-004 Parameter WORD_GAP_MS, default 1400, idle duration in ticks after a letter that emits a space.
REQ-005 clk  input  1  system clock; all logic on posedge clk.
REQ-006 rst_n  input  1  reset, synchronous, active-low.
REQ-007 btn  input  1  clean button level from the debounce stage; 1 = pressed; synchronous to clk.
REQ-008 char_valid  output  1  one-cycle pulse when char_code is updated.
REQ-009 char_code  output  8  ASCII of the last decoded character; held between pulses.
REQ-010 char_err  output  1  set with char_valid when the character is '?' due to no match or overflow; held until the next pulse.

Function
REQ-011 Prescaler counts 0..PRESCALE-1 and issues a tick on wrap; it is cleared on every state entry.
REQ-012 ms_cnt is 11 bits, increments on each tick, saturates at 2047, and clears on every state entry.
REQ-013 States: IDLE, PRESS, GAP, EMIT, SPACE.
REQ-014 IDLE: btn=1 -> PRESS; else if space_armed and ms_cnt reaches WORD_GAP_MS-LETTER_GAP_MS -> SPACE.
REQ-015 PRESS: btn=0 with ms_cnt=0 counts as a glitch and is discarded; go to GAP if sym_len>0, else IDLE.
REQ-016 PRESS: btn=0 with ms_cnt>0 classifies the symbol (dash = ms_cnt>=DOT_MAX_MS), writes it to sym_bits[sym_len] (1 = dash), increments sym_len, then goes to GAP.
REQ-017 sym_len is 3 bits with max 5 stored symbols; a 6th symbol sets overflow and leaves sym_bits unchanged; sym_len saturates at 5.
REQ-018 GAP: btn=1 -> PRESS, continuing the same letter; ms_cnt reaching LETTER_GAP_MS -> EMIT.
REQ-019 EMIT, one cycle:
  - char_valid=1.
  - char_code = lookup({sym_len, sym_bits}).
  - No match or overflow gives char_code 8'h3F and char_err=1; otherwise char_err=0.
  - sym_len, sym_bits and overflow are cleared; space_armed=1; next state IDLE.
REQ-020 SPACE, one cycle: char_valid=1, char_code=8'h20, char_err=0, space_armed=0, next state IDLE; at most one space is emitted per idle period.
REQ-021 Lookup covers A-Z and 0-9 (ITU Morse); all other patterns do not match.
REQ-022 btn=1 in the same cycle GAP reaches threshold: EMIT takes priority; IDLE then sees btn=1 on the next cycle and enters PRESS (2-cycle latency, no press lost).
REQ-023 Latency: char_valid asserts exactly 1 cycle after the tick on which ms_cnt reaches LETTER_GAP_MS in GAP.

Reset
REQ-024 rst_n=0 at a posedge forces:
  - state IDLE; prescaler, ms_cnt, sym_len, sym_bits, overflow and space_armed to 0.
  - char_valid=0, char_code=8'h00, char_err=0.
REQ-025 Reset in any state abandons the partial letter; no character is emitted for it.

Structure
REQ-026 Shared package morse_pkg holds the state enum, the ASCII constants ('?'=8'h3F, space=8'h20) and the symbol-length limit 5.
REQ-027 Sub-module morse_lut: combinational, input {len[2:0], bits[4:0]}, outputs ascii[7:0] and hit.

Verification (bench overrides PRESCALE=10; durations in ticks)
REQ-028 Press 100, release 700 -> one char_valid, char_code 8'h45 'E', char_err 0.
REQ-029 Sequences:
  - Press 100/release 100/press 300, then release 700 -> 8'h41 'A'.
  - Dash-dot-dot-dot -> 8'h42 'B'.
REQ-030 Press 199 then release 700 -> 8'h45; press 200 then release 700 -> 8'h54 'T'.
REQ-031 Six dots then release 700 -> char_code 8'h3F, char_err 1; the next letter decodes normally with char_err 0.
REQ-032 'E' followed by 3000 released ticks -> 'E' pulse, then exactly one 8'h20 pulse 800 ticks later, then none.
REQ-033 rst_n low one cycle during PRESS of the third symbol -> outputs 0, no pulse; a subsequent dot decodes as 'E'.
